// File: rtl/fm_ctrl_pkg.sv
// Shared types and default widths for the FM carrier sweep controller.
package fm_ctrl_pkg;

  localparam int DEF_PINC_WIDTH  = 32;
  localparam int DEF_DWELL_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    FM    = 2'd2
  } state_t;

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter that flags the last cycle of a dwell period.
// A load value of zero is treated as one so every step lasts at least a cycle.
module dwell_timer
  import fm_ctrl_pkg::*;
#(
  parameter int DWELL_WIDTH = DEF_DWELL_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_load,
  input  logic                   i_en,
  input  logic [DWELL_WIDTH-1:0] i_load_val,
  output logic                   o_last
);

  logic [DWELL_WIDTH-1:0] r_count;
  logic [DWELL_WIDTH-1:0] w_load_val;

  // Clamp the load value to a minimum of one cycle.
  always_comb begin
    w_load_val = i_load_val;
    if (i_load_val == '0) begin
      w_load_val = DWELL_WIDTH'(1);
    end
  end

  // Load has priority so a reload on the last cycle starts a fresh period.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= w_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - DWELL_WIDTH'(1);
    end
  end

  assign o_last = (r_count == DWELL_WIDTH'(1));

endmodule

// File: rtl/fm_sweep_controller.sv
// Stepped-frequency sweep sequencer for the FM carrier path, arbitrating
// between timed sweeps of the carrier phase increment and external FM mode.
module fm_sweep_controller
  import fm_ctrl_pkg::*;
#(
  parameter int CARRIER_PINC_WIDTH = DEF_PINC_WIDTH,
  parameter int DWELL_WIDTH        = DEF_DWELL_WIDTH
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          fm_request,
  input  logic                          continuous,
  input  logic [CARRIER_PINC_WIDTH-1:0] pinc_start,
  input  logic [CARRIER_PINC_WIDTH-1:0] pinc_stop,
  input  logic [CARRIER_PINC_WIDTH-1:0] pinc_step,
  input  logic [DWELL_WIDTH-1:0]        dwell_cycles,
  output logic                          fm_enable,
  output logic [CARRIER_PINC_WIDTH-1:0] phase_carrier,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err
);

  localparam int W = CARRIER_PINC_WIDTH;

  state_t r_state;
  state_t w_next_state;

  logic [W-1:0]           r_phase;
  logic [W-1:0]           r_start;
  logic [W-1:0]           r_stop;
  logic [W-1:0]           r_step;
  logic [DWELL_WIDTH-1:0] r_dwell;
  logic                   r_cont;
  logic                   r_busy;
  logic                   r_fm_enable;
  logic                   r_done;
  logic                   r_cfg_err;

  logic [W-1:0]           w_next_phase;
  logic [W:0]             w_sum;
  logic [W-1:0]           w_stepped;
  logic                   w_next_done;
  logic                   w_next_cfg_err;
  logic                   w_latch;
  logic                   w_load;
  logic                   w_last;
  logic [DWELL_WIDTH-1:0] w_load_val;

  // The first period takes its length from the live input; reloads use the latched copy.
  assign w_load_val = (r_state == IDLE) ? dwell_cycles : r_dwell;

  dwell_timer #(
    .DWELL_WIDTH(DWELL_WIDTH)
  ) u_dwell_timer (
    .i_clk     (aclk),
    .i_rst_n   (aresetn),
    .i_load    (w_load),
    .i_en      (r_state == DWELL),
    .i_load_val(w_load_val),
    .o_last    (w_last)
  );

  // Next step value, summed one bit wider so a step past the top saturates at stop instead of wrapping.
  always_comb begin
    w_sum     = {1'b0, r_phase} + {1'b0, r_step};
    w_stepped = w_sum[W-1:0];
    if (w_sum > {1'b0, r_stop}) begin
      w_stepped = r_stop;
    end
  end

  // Next-state and next-output decode; FM requests win in IDLE, sweeps are not preempted.
  always_comb begin
    w_next_state   = r_state;
    w_next_phase   = r_phase;
    w_next_done    = 1'b0;
    w_next_cfg_err = 1'b0;
    w_latch        = 1'b0;
    w_load         = 1'b0;
    case (r_state)
      IDLE: begin
        if (fm_request) begin
          w_next_state = FM;
        end else if (start) begin
          if ((pinc_step == '0) || (pinc_stop < pinc_start)) begin
            w_next_cfg_err = 1'b1;
          end else begin
            w_latch      = 1'b1;
            w_load       = 1'b1;
            w_next_phase = pinc_start;
            w_next_state = DWELL;
          end
        end
      end
      DWELL: begin
        if (abort) begin
          w_next_state = IDLE;
        end else if (w_last) begin
          if (r_phase == r_stop) begin
            if (r_cont) begin
              w_next_phase = r_start;
              w_load       = 1'b1;
            end else begin
              w_next_state = IDLE;
              w_next_done  = 1'b1;
            end
          end else begin
            w_next_phase = w_stepped;
            w_load       = 1'b1;
          end
        end
      end
      FM: begin
        if (!fm_request) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State, registered outputs and the sweep configuration captured at start.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_start     <= '0;
      r_stop      <= '0;
      r_step      <= '0;
      r_dwell     <= '0;
      r_cont      <= 1'b0;
      r_busy      <= 1'b0;
      r_fm_enable <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_phase     <= w_next_phase;
      r_busy      <= (w_next_state == DWELL);
      r_fm_enable <= (w_next_state == FM);
      r_done      <= w_next_done;
      r_cfg_err   <= w_next_cfg_err;
      if (w_latch) begin
        r_start <= pinc_start;
        r_stop  <= pinc_stop;
        r_step  <= pinc_step;
        r_dwell <= dwell_cycles;
        r_cont  <= continuous;
      end
    end
  end

  assign fm_enable     = r_fm_enable;
  assign phase_carrier = r_phase;
  assign busy          = r_busy;
  assign done          = r_done;
  assign cfg_err       = r_cfg_err;

endmodule

// File: tb/tb_fm_sweep_controller.sv
// Scoreboard bench for fm_sweep_controller: stimulus pushes per-cycle
// expectations, a monitor pops one per cycle and compares all outputs.
module tb_fm_sweep_controller;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start;
  logic        abort;
  logic        fm_request;
  logic        continuous;
  logic [31:0] pinc_start;
  logic [31:0] pinc_stop;
  logic [31:0] pinc_step;
  logic [15:0] dwell_cycles;
  logic        fm_enable;
  logic [31:0] phase_carrier;
  logic        busy;
  logic        done;
  logic        cfg_err;

  typedef struct packed {
    logic [15:0] tag;
    logic [31:0] phase;
    logic        busy;
    logic        done;
    logic        cfgErr;
    logic        fmEn;
  } expRec_t;

  expRec_t expQ[$];
  int checkCount = 0;
  int passCount  = 0;
  int scenario   = 0;
  int stepIdx    = 0;

  // Free-running 100 MHz clock.
  always #5 aclk = ~aclk;

  fm_sweep_controller dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .start        (start),
    .abort        (abort),
    .fm_request   (fm_request),
    .continuous   (continuous),
    .pinc_start   (pinc_start),
    .pinc_stop    (pinc_stop),
    .pinc_step    (pinc_step),
    .dwell_cycles (dwell_cycles),
    .fm_enable    (fm_enable),
    .phase_carrier(phase_carrier),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  task automatic beginScenario(input int s);
    scenario = s;
    stepIdx  = 0;
  endtask

  task automatic pushExp(input logic [31:0] ph, input logic b, input logic d,
                         input logic c, input logic f);
    expRec_t r;
    r.tag    = 16'(scenario * 100 + stepIdx);
    r.phase  = ph;
    r.busy   = b;
    r.done   = d;
    r.cfgErr = c;
    r.fmEn   = f;
    stepIdx++;
    expQ.push_back(r);
  endtask

  task automatic checkOutput(input expRec_t e);
    checkCount++;
    if (phase_carrier === e.phase && busy === e.busy && done === e.done &&
        cfg_err === e.cfgErr && fm_enable === e.fmEn) begin
      passCount++;
    end else begin
      $display("[TB] FAIL s%0d.c%0d got phase=%h busy=%b done=%b cfg_err=%b fm_enable=%b want phase=%h busy=%b done=%b cfg_err=%b fm_enable=%b",
               e.tag / 100, e.tag % 100 + 1, phase_carrier, busy, done, cfg_err, fm_enable,
               e.phase, e.busy, e.done, e.cfgErr, e.fmEn);
    end
  endtask

  // Drives one start pulse (raised here, dropped by releaseStart) with a configuration.
  task automatic applyStimulus(input logic [31:0] st, input logic [31:0] sp,
                               input logic [31:0] stp, input logic [15:0] dw,
                               input logic cont, input logic fmReq);
    @(negedge aclk);
    pinc_start   = st;
    pinc_stop    = sp;
    pinc_step    = stp;
    dwell_cycles = dw;
    continuous   = cont;
    fm_request   = fmReq;
    start        = 1'b1;
  endtask

  task automatic releaseStart();
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() > 0 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (expQ.size() > 0) begin
      checkCount++;
      $display("[TB] FAIL drain_timeout got %0d pending want 0", expQ.size());
      expQ.delete();
    end
  endtask

  // Monitor: one expectation per cycle, sampled just after the active edge.
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (expQ.size() > 0) begin
        checkOutput(expQ.pop_front());
      end
    end
  end

  // Directed stimulus with hand-computed per-cycle expectations.
  initial begin
    aresetn      = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    fm_request   = 1'b0;
    continuous   = 1'b0;
    pinc_start   = '0;
    pinc_stop    = '0;
    pinc_step    = '0;
    dwell_cycles = '0;

    beginScenario(0);
    repeat (3) @(negedge aclk);
    pushExp(32'd0, 0, 0, 0, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    pushExp(32'd0, 0, 0, 0, 0);
    pushExp(32'd0, 0, 0, 0, 0);
    waitDrain();

    beginScenario(1);
    applyStimulus(32'd100, 32'd130, 32'd10, 16'd3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 3; k++) pushExp(32'(100 + 10 * i), 1, 0, 0, 0);
    end
    pushExp(32'd130, 0, 1, 0, 0);
    pushExp(32'd130, 0, 0, 0, 0);
    releaseStart();
    waitDrain();

    beginScenario(2);
    applyStimulus(32'd0, 32'd25, 32'd10, 16'd0, 1'b0, 1'b0);
    pushExp(32'd0,  1, 0, 0, 0);
    pushExp(32'd10, 1, 0, 0, 0);
    pushExp(32'd20, 1, 0, 0, 0);
    pushExp(32'd25, 1, 0, 0, 0);
    pushExp(32'd25, 0, 1, 0, 0);
    pushExp(32'd25, 0, 0, 0, 0);
    releaseStart();
    waitDrain();

    beginScenario(3);
    applyStimulus(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 16'd1, 1'b0, 1'b0);
    pushExp(32'hFFFF_FFF0, 1, 0, 0, 0);
    pushExp(32'hFFFF_FFFF, 1, 0, 0, 0);
    pushExp(32'hFFFF_FFFF, 0, 1, 0, 0);
    pushExp(32'hFFFF_FFFF, 0, 0, 0, 0);
    releaseStart();
    waitDrain();

    beginScenario(4);
    applyStimulus(32'd5, 32'd7, 32'd1, 16'd2, 1'b1, 1'b0);
    pushExp(32'd5, 1, 0, 0, 0);
    pushExp(32'd5, 1, 0, 0, 0);
    pushExp(32'd6, 1, 0, 0, 0);
    pushExp(32'd6, 1, 0, 0, 0);
    pushExp(32'd7, 1, 0, 0, 0);
    pushExp(32'd7, 1, 0, 0, 0);
    pushExp(32'd5, 1, 0, 0, 0);
    pushExp(32'd5, 1, 0, 0, 0);
    pushExp(32'd6, 1, 0, 0, 0);
    pushExp(32'd6, 1, 0, 0, 0);
    pushExp(32'd6, 0, 0, 0, 0);
    pushExp(32'd6, 0, 0, 0, 0);
    releaseStart();
    repeat (9) @(negedge aclk);
    abort = 1'b1;
    @(negedge aclk);
    abort = 1'b0;
    waitDrain();

    beginScenario(5);
    applyStimulus(32'd10, 32'd20, 32'd1, 16'd1, 1'b0, 1'b1);
    pushExp(32'd6, 0, 0, 0, 1);
    pushExp(32'd6, 0, 0, 0, 1);
    releaseStart();
    waitDrain();
    @(negedge aclk);
    start = 1'b1;
    abort = 1'b1;
    pushExp(32'd6, 0, 0, 0, 1);
    pushExp(32'd6, 0, 0, 0, 1);
    @(negedge aclk);
    start = 1'b0;
    abort = 1'b0;
    waitDrain();
    @(negedge aclk);
    fm_request = 1'b0;
    pushExp(32'd6, 0, 0, 0, 0);
    pushExp(32'd6, 0, 0, 0, 0);
    waitDrain();

    beginScenario(6);
    applyStimulus(32'd0, 32'd2, 32'd1, 16'd1, 1'b0, 1'b0);
    pushExp(32'd0, 1, 0, 0, 0);
    pushExp(32'd1, 1, 0, 0, 0);
    pushExp(32'd2, 1, 0, 0, 0);
    pushExp(32'd2, 0, 1, 0, 0);
    pushExp(32'd2, 0, 0, 0, 1);
    releaseStart();
    fm_request = 1'b1;
    pinc_stop  = 32'd100;
    pinc_start = 32'd50;
    waitDrain();
    @(negedge aclk);
    fm_request = 1'b0;
    pushExp(32'd2, 0, 0, 0, 0);
    waitDrain();

    beginScenario(7);
    applyStimulus(32'd10, 32'd20, 32'd0, 16'd4, 1'b0, 1'b0);
    pushExp(32'd2, 0, 0, 1, 0);
    pushExp(32'd2, 0, 0, 0, 0);
    releaseStart();
    waitDrain();

    beginScenario(8);
    applyStimulus(32'd20, 32'd10, 32'd1, 16'd4, 1'b0, 1'b0);
    pushExp(32'd2, 0, 0, 1, 0);
    pushExp(32'd2, 0, 0, 0, 0);
    releaseStart();
    waitDrain();

    beginScenario(9);
    applyStimulus(32'd40, 32'd40, 32'd5, 16'd2, 1'b0, 1'b0);
    pushExp(32'd40, 1, 0, 0, 0);
    pushExp(32'd40, 1, 0, 0, 0);
    pushExp(32'd40, 0, 1, 0, 0);
    pushExp(32'd40, 0, 0, 0, 0);
    releaseStart();
    waitDrain();

    beginScenario(10);
    applyStimulus(32'd100, 32'd130, 32'd10, 16'd3, 1'b0, 1'b0);
    pushExp(32'd100, 1, 0, 0, 0);
    pushExp(32'd100, 1, 0, 0, 0);
    pushExp(32'd100, 1, 0, 0, 0);
    pushExp(32'd0,   0, 0, 0, 0);
    pushExp(32'd0,   0, 0, 0, 0);
    releaseStart();
    repeat (2) @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    waitDrain();

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
